// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front end.
// Owns the PC and drives a combinational instruction memory. Each fetched
// {pc, instr} pair is queued in a DEPTH-entry FIFO. Decode pulls pairs from
// the FIFO head with a valid/ready handshake. A redirect flushes the FIFO and
// reloads the PC.
// Optional build macro: IFETCH_PERF_EN adds the perf_fetched and perf_stall
// counters.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]    pc_q;
  logic [31:0]    fifo_pc    [DEPTH];
  logic [31:0]    fifo_instr [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic           deq;
  logic           enq;
  logic           has_room;
  logic           unused_ok;

  // The low two bits of a redirect target are dropped; the PC stays word-aligned.
  assign unused_ok = &{1'b0, redirect_pc[1:0]};

  // Pointers wrap modulo DEPTH, so DEPTH does not need to be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign iaddr     = pc_q;
  assign out_valid = (count != '0);
  assign out_pc    = fifo_pc[rd_ptr];
  assign out_instr = fifo_instr[rd_ptr];

  // Handshake decode. A full FIFO still accepts a fetch when the head leaves in the same cycle.
  always_comb begin
    deq      = out_valid & out_ready;
    has_room = (count < CW'(DEPTH)) | deq;
    enq      = fetch_en & ~redirect_valid & has_room;
  end

  // PC update: a redirect wins; otherwise the PC advances by one word on each enqueue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[31:2], 2'b00};
    end else if (enq) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // FIFO pointers and occupancy. A redirect empties the FIFO even if the head was consumed in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage. Entries are cleared on reset so the head outputs read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (enq) begin
      fifo_pc[wr_ptr]    <= pc_q;
      fifo_instr[wr_ptr] <= idata;
    end
  end

`ifdef IFETCH_PERF_EN
  // Perf counters: count fetched words and the cycles a wanted fetch was blocked by a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (enq) perf_fetched <= perf_fetched + 32'd1;
      if (fetch_en & ~redirect_valid & ~enq) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed bench for ifetch_unit with a combinational memory model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int checks = 0;
  int errors = 0;
  int acc10  = 0;

  ifetch_unit dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .iaddr(iaddr), .idata(idata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef IFETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Memory contents: two fixed words, every other address returns a tagged copy of itself.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0fb3;
    if (a == 32'h4) return 32'h8000_10b7;
    return a ^ 32'h5A5A_0000;
  endfunction

  assign idata = mem(iaddr);

  // Count how many times the word at 0x10 is handed to decode.
  always @(posedge clk)
    if (rst_n && out_valid && out_ready && out_pc == 32'h10) acc10++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    // reset state
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc",    out_pc, 32'h0);
`ifdef IFETCH_PERF_EN
    chk("rst_pf", perf_fetched, 32'h0);
    chk("rst_ps", perf_stall, 32'h0);
`endif
    rst_n = 1'b1;

    // reset and stream
    step();
    chk("s0_valid", {31'b0, out_valid}, 32'h1);
    chk("s0_pc",    out_pc, 32'h0);
    chk("s0_instr", out_instr, 32'h0000_0fb3);
    step();
    chk("s1_valid", {31'b0, out_valid}, 32'h1);
    chk("s1_pc",    out_pc, 32'h4);
    chk("s1_instr", out_instr, 32'h8000_10b7);
    chk("s1_iaddr", iaddr, 32'h8);

    // restart at 0, then backpressure with word 0 at the head
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    chk("rs_valid", {31'b0, out_valid}, 32'h0);
    step();
    chk("rs_pc", out_pc, 32'h0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_count", 32'(dut.count), 32'd2);
      chk("bp_iaddr", iaddr, 32'h8);
      chk("bp_instr", out_instr, 32'h0000_0fb3);
    end
    out_ready = 1'b1;
    step();
    chk("rel_pc4", out_pc, 32'h4);
    chk("rel_v4",  {31'b0, out_valid}, 32'h1);
    step();
    chk("rel_pc8", out_pc, 32'h8);
    chk("rel_in8", out_instr, 32'h5A5A_0008);

    // redirect while full
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0013;
    step();
    redirect_valid = 1'b0;
    chk("rf_valid", {31'b0, out_valid}, 32'h0);
    chk("rf_iaddr", iaddr, 32'h10);
    step();
    chk("rf_pc",    out_pc, 32'h10);
    chk("rf_instr", out_instr, 32'h5A5A_0010);
    step();
    chk("rf_full",  32'(dut.count), 32'd2);

    // dequeue and redirect in the same cycle
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h1C;
    step();
    redirect_valid = 1'b0;
    chk("dr_valid", {31'b0, out_valid}, 32'h0);
    chk("dr_iaddr", iaddr, 32'h1C);
    step();
    chk("dr_pc",    out_pc, 32'h1C);
    chk("dr_once",  32'(acc10), 32'd1);

    // wrap-around
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    chk("wr_pcFC", out_pc, 32'hFFFF_FFFC);
    step();
    chk("wr_pc0",  out_pc, 32'h0);
    chk("wr_in0",  out_instr, 32'h0000_0fb3);
    chk("wr_ia",   iaddr, 32'h4);

    // fill one more, then drop fetch_en and drain
    out_ready = 1'b0;
    step();
    chk("fe_full", 32'(dut.count), 32'd2);
    fetch_en = 1'b0; out_ready = 1'b1;
    step();
    chk("fe_pc4",  out_pc, 32'h4);
    chk("fe_ia1",  iaddr, 32'h8);
    step();
    chk("fe_empty", {31'b0, out_valid}, 32'h0);
    step();
    chk("fe_ia2",  iaddr, 32'h8);

    // async reset between edges
    fetch_en = 1'b1; out_ready = 1'b0;
    step();
    chk("ar_pre", {31'b0, out_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, out_valid}, 32'h0);
    chk("ar_iaddr", iaddr, 32'h0);
    chk("ar_count", 32'(dut.count), 32'd0);
`ifdef IFETCH_PERF_EN
    chk("ar_pf", perf_fetched, 32'h0);
    chk("ar_ps", perf_stall, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar_restart", out_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch front end for the CPU core. It owns the program counter and drives the address into the instruction memory. The instruction memory is combinational: `iaddr` goes in and `idata` comes back in the same cycle. Fetched words are held in a small FIFO and presented to decode with a valid/ready handshake. The unit supports stall via backpressure, a fetch enable, and branch/jump redirect with flush.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded at reset. Bits [1:0] must be 0.
- `DEPTH`, default `2`: instruction FIFO entries. Legal range is 2–8.
- `clk` input, 1 bit: the only clock. All state updates on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `fetch_en` input, 1 bit: when 0, no new fetches are issued. Drain and redirect still work.
- `iaddr` output, 32 bits: instruction memory address, equal to the registered PC.
- `idata` input, 32 bits: instruction memory read data, valid in the same cycle as `iaddr`.
- `redirect_valid` input, 1 bit: one-cycle pulse requesting a PC change.
- `redirect_pc` input, 32 bits: redirect target. Bits [1:0] are ignored and forced to 0.
- `out_valid` output, 1 bit: the FIFO head is valid.
- `out_ready` input, 1 bit: decode accepts the head.
- `out_instr` output, 32 bits: instruction at the FIFO head.
- `out_pc` output, 32 bits: PC of the instruction at the FIFO head.

## Operation
- State: `pc` register, a `DEPTH`-entry FIFO holding {pc, instr} pairs, and a `count` register.
- Reset values:
  - `pc = RESET_PC`, `count = 0`.
  - `out_valid = 0`, `out_instr = 0`, `out_pc = 0`.
  - `iaddr = RESET_PC`.
- Dequeue (`deq`) = `out_valid & out_ready`.
- Enqueue (`enq`) = `fetch_en & ~redirect_valid & (count < DEPTH | deq)`.
- On `enq`:
  - the pair {pc, idata} is written to the FIFO tail;
  - `pc <= pc + 4`, wrapping modulo 2^32 (0xFFFF_FFFC becomes 0x0000_0000).
- Enqueue and dequeue in the same cycle: `count` is unchanged. This is legal when full (pass-through refill).
- On `redirect_valid`, which has priority over everything else:
  - all FIFO entries are invalidated and `count <= 0`;
  - `pc <= {redirect_pc[31:2], 2'b00}`;
  - nothing is enqueued in that cycle.
- A dequeue in the redirect cycle still completes: decode consumed that word, and the flush does not retract it.
- When `fetch_en` is 0, `pc` holds and the FIFO drains normally.
- When full with no dequeue, `pc` holds and `iaddr` is stable.
- `out_instr` and `out_pc` come straight from the FIFO head registers. They are stable while `out_valid & ~out_ready`.

## Timing
- `iaddr` is registered and changes only after a clock edge or on reset assertion.
- Fetch latency from reset release with `fetch_en = 1`:
  - cycle 0 edge: word at `RESET_PC` is enqueued;
  - after that edge: `out_valid = 1`.
  - Latency is 1 cycle.
- Redirect latency:
  - redirect sampled at edge N;
  - `iaddr = target` after edge N;
  - target word is enqueued at edge N+1 and visible on `out_*` after edge N+1.
  - Redirect-to-out_valid is 2 edges.
- Sustained throughput is 1 instruction per cycle while `out_ready = 1` and no redirect.
- Asserting `rst_n` mid-operation immediately clears `out_valid` and `count` and sets `iaddr = RESET_PC`. This does not wait for a clock edge.

## Configuration
- `IFETCH_PERF_EN` defined:
  - adds output `perf_fetched` [31:0], incremented on each enqueue;
  - adds output `perf_stall` [31:0], incremented on each cycle with `fetch_en & ~redirect_valid & ~enq`.
  - Both counters reset to 0 and wrap at 2^32.
- `IFETCH_PERF_EN` undefined: neither port nor counter exists. Fetch behaviour is identical in both builds.

## Test plan
- Reset and stream. Memory word0 = 32'h00000fb3, word1 = 32'h800010b7; hold `out_ready = 1`; release reset.
  - Expect `out_pc` 0 then 4.
  - Expect `out_instr` 0x00000fb3 then 0x800010b7 on consecutive cycles.
- Backpressure. Hold `out_ready = 0` for 5 cycles.
  - `count` saturates at 2 and `iaddr` holds at 8.
  - `out_instr` stays 0x00000fb3.
  - Release: words at 0, 4, 8 arrive in order with no gap.
- Redirect while full. Pulse `redirect_valid` with `redirect_pc = 32'h0000_0013` while `out_valid = 1` and `out_ready = 0`.
  - Next cycle: `out_valid = 0` and `iaddr = 0x10`.
  - One cycle later: `out_pc = 0x10`.
- Simultaneous dequeue and redirect. `out_ready = 1` with a redirect to 0x1C in the same cycle.
  - The head is consumed exactly once.
  - The next delivered `out_pc` is 0x1C, with no stale word from 4 or 8.
- Wrap-around and `fetch_en`.
  - Redirect to 0xFFFF_FFFC: the following `out_pc` values are 0xFFFF_FFFC then 0x0000_0000.
  - Drop `fetch_en`: `iaddr` freezes and the FIFO drains to `out_valid = 0`.
- Async reset mid-stream. Assert `rst_n = 0` between edges.
  - `out_valid = 0` and `iaddr = RESET_PC` immediately.
  - With `IFETCH_PERF_EN`, both counters read 0.
